parity_tx: RTL and testbench
============================

# parity_tx

Serial line transmitter that sits directly downstream of the 5-bit even-parity generator. It accepts the generator's 6-bit word {data[4:0], parity}, re-checks the parity bit and shifts the word out on a single line as a framed serial bit stream: start bit, 6 payload bits MSB first, stop bit. A valid/ready-style strobe lets the generator stage issue back-to-back frames with no idle gap.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit time; legal range 1..256.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_in  in  6  word to send: [5:1] data, [0] even parity bit.
- start  in  1  load request; sampled only when ready=1.
- ready  out  1  high when idle and able to accept start.
- busy  out  1  high while a frame is on the line; equals ~ready.
- tx  out  1  serial line; idles high; registered.
- done  out  1  one-cycle pulse on the first idle cycle after a stop bit.
- par_err  out  1  parity check result of the last accepted frame.

## Operation
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, ready=1.
  - IDLE & start: load the shift register with frame_in, load par_err, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send frame_in[5] first, down to frame_in[0]. Each bit lasts CLKS_PER_BIT cycles. A 3-bit index counts 0..5; after index 5 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for one cycle.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary. Its width is clog2(CLKS_PER_BIT), with a minimum of 1 bit. When CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- Parity check at load: par_err = frame_in[5]^frame_in[4]^frame_in[3]^frame_in[2]^frame_in[1]^frame_in[0].
  - The result is 0 for a correct even-parity word.
  - It is registered at acceptance and held until the next accepted start.
  - The frame is transmitted regardless of par_err.
- The word is captured at acceptance. Later changes on frame_in do not affect the frame in flight.
- start while busy=1 is ignored: no queueing, no error flag.
- Back-to-back frames: done and ready are both high in the same cycle. A start in that cycle is accepted, so the stop bit is followed immediately by the next start bit.
- Reset:
  - Reset values: tx=1, ready=1, busy=0, done=0, par_err=0. The FSM returns to IDLE and all counters go to 0.
  - Reset has priority over start in the same cycle.
  - Reset mid-frame aborts the frame: tx is 1 from the next cycle and no done pulse is produced.

## Timing
- start accepted on edge k:
  - busy=1 and tx=0 from cycle k+1.
  - Start bit occupies cycles k+1 .. k+CLKS_PER_BIT.
- Payload bit i (i=0..5, where i=0 is frame_in[5]) occupies cycles k+1+(i+1)·CLKS_PER_BIT .. k+(i+2)·CLKS_PER_BIT.
- Stop bit occupies cycles k+1+7·CLKS_PER_BIT .. k+8·CLKS_PER_BIT.
- Cycle k+8·CLKS_PER_BIT+1: done=1, ready=1, tx=1.
- Frame length is 8·CLKS_PER_BIT cycles. Maximum throughput is one frame per 8·CLKS_PER_BIT cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Test plan
- CLKS_PER_BIT=4, frame_in=6'b101101 (data 10110, parity 1), start for one cycle:
  - tx reads 0,1,0,1,1,0,1,1, each held 4 cycles.
  - done pulses 33 cycles after the start edge.
  - par_err=0.
- CLKS_PER_BIT=4, frame_in=6'b101100 (bad parity): same framing with last payload bit 0; par_err=1 and held after done.
- Busy rejection:
  - Issue start with 6'b000000.
  - Pulse start with 6'b111111 at cycle 10 of the frame.
  - Required: the first frame is unchanged, no second frame follows, and ready stays 0 until done.
- Back-to-back:
  - Hold start=1 continuously with frame_in=6'b110000 and then 6'b011110 (presented in the done cycle).
  - Required: the stop bit of frame 1 is followed directly by the start bit of frame 2, with no idle high cycles in between.
- Reset mid-frame:
  - Assert rst for one cycle during payload bit 3.
  - Required: tx=1, busy=0, done=0, par_err=0 on the next cycle, and a fresh start transmits correctly.
- CLKS_PER_BIT=1, frame_in=6'b010100: the 8-cycle frame reads 0,0,1,0,1,0,0,1, and done arrives on cycle k+9.

Source files
------------

// File: rtl/parity_tx_if.sv
// Handshake and line bundle between the parity generator stage and parity_tx.
//   frame_in[5:0] : word to send, [5:1] data, [0] even parity bit
//   start         : load request, honoured only while ready=1
//   ready / busy  : idle-and-accepting / frame on the line (complements)
//   tx            : serial line, idles high
//   done          : one-cycle pulse on the first idle cycle after a stop bit
//   par_err       : parity check of the last accepted frame
// master = generator side, slave = transmitter.
interface parity_tx_if;
  logic [5:0] frame_in;
  logic       start;
  logic       ready;
  logic       busy;
  logic       tx;
  logic       done;
  logic       par_err;

  modport master (
    output frame_in, start,
    input  ready, busy, tx, done, par_err
  );

  modport slave (
    input  frame_in, start,
    output ready, busy, tx, done, par_err
  );
endinterface

// File: rtl/parity_tx.sv
// Framed serial transmitter for 6-bit even-parity words.
// Frame: start bit (0), frame_in[5] .. frame_in[0], stop bit (1); each bit
// lasts CLKS_PER_BIT clocks. The word and its parity check are captured when
// start is accepted.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : parity_tx_if slave modport (frame_in, start, ready, busy, tx,
//         done, par_err)
module parity_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic         clk,
  input logic         rst,
  parity_tx_if.slave  bus
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic [5:0]    shreg;
  logic          ready_r;
  logic          tx_r;
  logic          done_r;
  logic          perr_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      idx     <= '0;
      shreg   <= '0;
      ready_r <= 1'b1;
      tx_r    <= 1'b1;
      done_r  <= 1'b0;
      perr_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (bus.start) begin
            shreg   <= bus.frame_in;
            perr_r  <= ^bus.frame_in;
            state   <= START;
            ready_r <= 1'b0;
            tx_r    <= 1'b0;
            timer   <= '0;
            idx     <= '0;
          end
        end

        START: begin
          if (timer == LAST_TICK) begin
            timer <= '0;
            state <= DATA;
            tx_r  <= shreg[5];
            shreg <= {shreg[4:0], 1'b0};
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DATA: begin
          if (timer == LAST_TICK) begin
            timer <= '0;
            if (idx == 3'd5) begin
              state <= STOP;
              tx_r  <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              tx_r  <= shreg[5];
              shreg <= {shreg[4:0], 1'b0};
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        STOP: begin
          // Returning to IDLE raises ready together with done, so a start
          // presented in the done cycle launches the next start bit at once.
          if (timer == LAST_TICK) begin
            timer   <= '0;
            idx     <= '0;
            state   <= IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready   = ready_r;
  assign bus.busy    = ~ready_r;
  assign bus.tx      = tx_r;
  assign bus.done    = done_r;
  assign bus.par_err = perr_r;

endmodule

// File: tb/tb_parity_tx.sv
module tb_parity_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parity_tx_if a ();
  parity_tx_if b ();

  parity_tx #(.CLKS_PER_BIT(4)) dut_a (.clk(clk), .rst(rst), .bus(a));
  parity_tx #(.CLKS_PER_BIT(1)) dut_b (.clk(clk), .rst(rst), .bus(b));

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [5:0] f;
    logic [7:0] bits;   // start, 6 payload MSB first, stop
    logic       perr;
  } vec_t;

  typedef struct {
    logic [7:0] bits;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expand4(input logic [7:0] bits);
    logic [31:0] s;
    s = '0;
    for (int i = 7; i >= 0; i--)
      for (int j = 0; j < 4; j++)
        s = {s[30:0], bits[i]};
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits for done on DUT a; n = number of falling edges sampled (1 = the
  // cycle right after the call point)
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a.done && n < 300);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!a.ready && t < 300) begin
      tick();
      t++;
    end
    check("ready_timeout", (t < 300), 1);
  endtask

  task automatic send_check(input vec_t v);
    int n;
    exp_t e;
    wait_ready();
    a.frame_in = v.f;
    a.start    = 1'b1;
    e.bits = v.bits;
    e.perr = v.perr;
    sb.push_back(e);
    tick();
    a.start    = 1'b0;
    a.frame_in = ~v.f;              // must not disturb the frame in flight
    @(negedge clk);
    check("busy_after_accept", a.busy, 1);
    check("start_bit_low", a.tx, 0);
    wait_done(n);
    check("done_latency", n + 1, 33);
    repeat (3) tick();
    @(negedge clk);
    check("par_err_hold", a.par_err, v.perr);
  endtask

  // Scoreboard monitor for DUT a: captures every busy cycle of tx and
  // compares against the oldest queued expectation when done pulses.
  logic        in_frame = 1'b0;
  int          cnt      = 0;
  logic [31:0] stream   = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (a.busy && !in_frame) begin
        in_frame = 1'b1;
        cnt      = 0;
        stream   = '0;
      end
      if (in_frame && a.busy) begin
        stream = {stream[30:0], a.tx};
        cnt++;
      end
      if (a.done) begin
        in_frame = 1'b0;
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got a frame, expected none queued");
        end else begin
          e = sb.pop_front();
          check("frame_stream", stream, expand4(e.bits));
          check("frame_len", cnt, 32);
          check("done_par_err", a.par_err, e.perr);
          check("done_tx_high", a.tx, 1);
          check("done_ready", a.ready, 1);
        end
      end
    end
  end

  initial begin
    int   n;
    logic saw;
    logic bad;
    logic [7:0] bits;
    exp_t e;

    vecs[0] = '{6'b101101, 8'b01011011, 1'b0};
    vecs[1] = '{6'b101100, 8'b01011001, 1'b1};
    vecs[2] = '{6'b111111, 8'b01111111, 1'b0};
    vecs[3] = '{6'b010100, 8'b00101001, 1'b0};
    vecs[4] = '{6'b100000, 8'b01000001, 1'b1};
    vecs[5] = '{6'b000001, 8'b00000011, 1'b1};

    // reset with a simultaneous start: reset wins
    a.frame_in = 6'b111111;
    a.start    = 1'b1;
    b.frame_in = 6'b111111;
    b.start    = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_prio_busy", a.busy, 0);
    a.start = 1'b0;
    b.start = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_tx", a.tx, 1);
    check("reset_ready", a.ready, 1);
    check("reset_busy", a.busy, 0);
    check("reset_done", a.done, 0);
    check("reset_par_err", a.par_err, 0);
    check("reset_b_tx", b.tx, 1);
    check("reset_b_busy", b.busy, 0);

    // table-driven frames
    for (int i = 0; i < 6; i++) send_check(vecs[i]);

    // busy rejection: second start at cycle 10 of the frame is ignored
    wait_ready();
    a.frame_in = 6'b000000;
    a.start    = 1'b1;
    e.bits = 8'b00000001;
    e.perr = 1'b0;
    sb.push_back(e);
    tick();
    a.start = 1'b0;
    repeat (9) tick();
    a.frame_in = 6'b111111;
    a.start    = 1'b1;
    tick();
    a.start = 1'b0;
    bad = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!a.done && a.ready) bad = 1'b1;
    end while (!a.done && n < 300);
    check("reject_done_seen", a.done, 1);
    check("reject_ready_low", bad, 0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (a.busy) saw = 1'b1;
    end
    check("reject_no_second_frame", saw, 0);

    // back-to-back with start held high
    wait_ready();
    a.frame_in = 6'b110000;
    a.start    = 1'b1;
    e.bits = 8'b01100001;
    e.perr = 1'b0;
    sb.push_back(e);
    tick();
    wait_done(n);
    check("b2b_first_latency", n + 1, 34);
    a.frame_in = 6'b011110;
    e.bits = 8'b00111101;
    e.perr = 1'b0;
    sb.push_back(e);
    tick();
    a.start = 1'b0;
    @(negedge clk);
    check("b2b_start_bit", a.tx, 0);
    check("b2b_busy", a.busy, 1);
    wait_done(n);
    check("b2b_second_latency", n + 1, 33);

    // reset during payload bit 3
    wait_ready();
    a.frame_in = 6'b101100;
    a.start    = 1'b1;
    tick();
    a.start = 1'b0;
    repeat (17) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tx", a.tx, 1);
    check("midrst_busy", a.busy, 0);
    check("midrst_done", a.done, 0);
    check("midrst_par_err", a.par_err, 0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (a.done) saw = 1'b1;
    end
    check("midrst_no_done", saw, 0);
    send_check(vecs[0]);

    // CLKS_PER_BIT = 1
    b.frame_in = 6'b010100;
    b.start    = 1'b1;
    tick();
    b.start    = 1'b0;
    b.frame_in = 6'b101011;
    bits = '0;
    saw  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bits = {bits[6:0], b.tx};
      if (b.done) saw = 1'b1;
    end
    @(negedge clk);
    check("c1_stream", bits, 8'b00101001);
    check("c1_no_early_done", saw, 0);
    check("c1_done_k9", b.done, 1);
    check("c1_par_err", b.par_err, 0);

    repeat (5) tick();
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
